// File: rtl/minibus_pipe_decoder.sv
// Registered minibus address decoder: latches a master request, decodes it against
// programmable windows (lowest index wins), runs a per-transaction watchdog and returns a one-cycle response.
module minibus_pipe_decoder #(
  parameter int SLAVE_COUNT    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_ren,
  input  logic                          m_wen,
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [DATA_W-1:0]             m_wdata,
  output logic                          m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_error,
  input  logic [SLAVE_COUNT*ADDR_W-1:0] map_start,
  input  logic [SLAVE_COUNT*ADDR_W-1:0] map_end,
  output logic [SLAVE_COUNT-1:0]        s_sel,
  output logic                          s_ren,
  output logic                          s_wen,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [SLAVE_COUNT-1:0]        s_ready,
  input  logic [SLAVE_COUNT*DATA_W-1:0] s_rdata,
  input  logic [SLAVE_COUNT-1:0]        s_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam bit               LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LP_WDOG_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_ren;
  logic                   r_wen;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [SLAVE_COUNT-1:0] r_sel;
  logic [CNT_W-1:0]       r_wdog;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_error;

  logic                   w_req;
  logic                   w_hit;
  logic [SLAVE_COUNT-1:0] w_hit_oh;
  logic                   w_sel_ready;
  logic                   w_sel_error;
  logic [DATA_W-1:0]      w_sel_rdata;
  logic                   w_timeout;
  logic                   w_in_access;

  assign w_req = m_ren | m_wen;

  // Scan from the top index down so the lowest matching window is the one that sticks.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_oh = '0;
    for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
      if ((map_start[i*ADDR_W +: ADDR_W] < map_end[i*ADDR_W +: ADDR_W]) &&
          (m_addr >= map_start[i*ADDR_W +: ADDR_W]) &&
          (m_addr <  map_end[i*ADDR_W +: ADDR_W])) begin
        w_hit       = 1'b1;
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_sel_ready = |(s_ready & r_sel);
  assign w_sel_error = |(s_error & r_sel);
  assign w_timeout   = LP_WDOG_EN && (r_wdog == LP_WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_req) w_next = w_hit ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (w_sel_ready || w_timeout) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request latch, watchdog and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_wdog  <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_ren   <= m_ren & ~m_wen;
            r_wen   <= m_wen;
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_sel   <= w_hit_oh;
            r_error <= ~w_hit;
            r_rdata <= '0;
          end
        end
        ST_ACCESS: begin
          r_wdog <= r_wdog + CNT_W'(1);
          if (w_sel_ready) begin
            r_error <= w_sel_error;
            r_rdata <= (r_wen || w_sel_error) ? '0 : w_sel_rdata;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_rdata <= '0;
          end
        end
        ST_RESP: begin
          r_wdog  <= '0;
          r_error <= 1'b0;
          r_rdata <= '0;
        end
        default: begin
          r_wdog <= '0;
        end
      endcase
    end
  end

  // Outputs gated by state so reset drops them immediately
  assign w_in_access = (r_state == ST_ACCESS);
  assign s_sel       = w_in_access ? r_sel : '0;
  assign s_ren       = w_in_access & r_ren;
  assign s_wen       = w_in_access & r_wen;
  assign s_addr      = r_addr;
  assign s_wdata     = r_wdata;
  assign m_ready     = (r_state == ST_RESP);
  assign m_rdata     = m_ready ? r_rdata : '0;
  assign m_error     = m_ready & r_error;

endmodule

// File: tb/tb_minibus_pipe_decoder.sv
// Directed bench for minibus_pipe_decoder with a 4-cycle watchdog.
module tb_minibus_pipe_decoder;
  localparam int SC = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_ren, m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          m_error;
  logic [SC*AW-1:0] map_start, map_end;
  logic [SC-1:0] s_sel;
  logic          s_ren, s_wen;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [SC-1:0] s_ready;
  logic [SC*DW-1:0] s_rdata;
  logic [SC-1:0] s_error;

  int n_checks = 0;
  int n_fail   = 0;

  minibus_pipe_decoder #(
    .SLAVE_COUNT(SC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_error(m_error),
    .map_start(map_start), .map_end(map_end),
    .s_sel(s_sel), .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_error(s_error)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int i, input logic [AW-1:0] st, input logic [AW-1:0] en);
    map_start[i*AW +: AW] = st;
    map_end[i*AW +: AW]   = en;
  endtask

  task automatic std_map();
    set_win(0, 32'h0000, 32'h1000);
    set_win(1, 32'h1000, 32'h2000);
    set_win(2, 32'h0, 32'h0);
    set_win(3, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ren = 1'b1; m_wen = 1'b0; m_addr = 32'h1004; m_wdata = 32'h1;
    s_ready = '0; s_rdata = '0; s_error = '0;
    std_map();
    tick();
    @(negedge clk);
    n_checks++;
    if ({m_ready, m_error, s_ren, s_wen} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {m_ready, m_error, s_ren, s_wen});
    end
    n_checks++;
    if ({s_sel, m_rdata, s_addr, s_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: sel %b rdata %h addr %h wdata %h required all 0", s_sel, m_rdata, s_addr, s_wdata);
    end
    m_ren = 1'b0; m_addr = '0; m_wdata = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_mapped();
    m_ren = 1'b1; m_addr = 32'h1004;
    @(negedge clk);
    n_checks++;
    if (s_sel !== 4'b0000) begin
      n_fail++; $display("FAIL rd_c0_sel: got %b required 0000", s_sel);
    end
    tick();
    m_ren = 1'b0; m_addr = '0;
    for (int c = 1; c <= 3; c++) begin
      s_ready = (c == 2) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      s_error = (c == 2) ? 4'b0001 : 4'b0000;
      if (c == 3) s_rdata[1*DW +: DW] = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (s_sel !== 4'b0010 || s_ren !== 1'b1 || m_ready !== 1'b0) begin
        n_fail++; $display("FAIL rd_access_c%0d: sel %b ren %b ready %b required 0010 1 0", c, s_sel, s_ren, m_ready);
      end
      tick();
      s_ready = '0; s_error = '0;
    end
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_rdata !== 32'hDEADBEEF || m_error !== 1'b0 || s_sel !== 4'b0000) begin
      n_fail++; $display("FAIL rd_resp: ready %b rdata %h err %b sel %b required 1 deadbeef 0 0000", m_ready, m_rdata, m_error, s_sel);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0 || m_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_after: ready %b rdata %h required 0 0", m_ready, m_rdata);
    end
    s_rdata = '0;
  endtask

  task automatic test_write();
    m_wen = 1'b1; m_addr = 32'h0010; m_wdata = 32'h55AA;
    tick();
    m_wen = 1'b0; m_addr = '0; m_wdata = '0;
    s_ready = 4'b0001; s_rdata[0 +: DW] = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (s_wen !== 1'b1 || s_ren !== 1'b0 || s_wdata !== 32'h55AA || s_addr !== 32'h10 || s_sel !== 4'b0001) begin
      n_fail++; $display("FAIL wr_access: wen %b ren %b wdata %h addr %h sel %b required 1 0 55aa 10 0001", s_wen, s_ren, s_wdata, s_addr, s_sel);
    end
    tick();
    s_ready = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_rdata !== 32'h0 || m_error !== 1'b0 || s_wen !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp: ready %b rdata %h err %b wen %b required 1 0 0 0", m_ready, m_rdata, m_error, s_wen);
    end
    n_checks++;
    if (s_wdata !== 32'h55AA) begin
      n_fail++; $display("FAIL wr_hold: wdata %h required 55aa", s_wdata);
    end
    tick();
    s_rdata = '0;
  endtask

  task automatic test_rw_both();
    m_ren = 1'b1; m_wen = 1'b1; m_addr = 32'h1010; m_wdata = 32'hCAFE;
    tick();
    m_ren = 1'b0; m_wen = 1'b0;
    s_ready = 4'b0010; s_rdata[1*DW +: DW] = 32'h77777777;
    @(negedge clk);
    n_checks++;
    if (s_ren !== 1'b0 || s_wen !== 1'b1 || s_sel !== 4'b0010) begin
      n_fail++; $display("FAIL rw_access: ren %b wen %b sel %b required 0 1 0010", s_ren, s_wen, s_sel);
    end
    tick();
    s_ready = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_rdata !== 32'h0 || m_error !== 1'b0) begin
      n_fail++; $display("FAIL rw_resp: ready %b rdata %h err %b required 1 0 0", m_ready, m_rdata, m_error);
    end
    tick();
    s_rdata = '0;
  endtask

  task automatic test_unmapped();
    m_ren = 1'b1; m_addr = 32'h9000;
    tick();
    m_ren = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_error !== 1'b1 || m_rdata !== 32'h0 || s_sel !== 4'b0000) begin
      n_fail++; $display("FAIL unmapped_resp: ready %b err %b rdata %h sel %b required 1 1 0 0000", m_ready, m_error, m_rdata, s_sel);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0 || m_error !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_after: ready %b err %b required 0 0", m_ready, m_error);
    end
  endtask

  task automatic test_slave_error();
    m_ren = 1'b1; m_addr = 32'h0004;
    tick();
    m_ren = 1'b0;
    s_ready = 4'b0001; s_error = 4'b0001; s_rdata[0 +: DW] = 32'hFFFF;
    tick();
    s_ready = '0; s_error = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_error !== 1'b1 || m_rdata !== 32'h0) begin
      n_fail++; $display("FAIL slverr_resp: ready %b err %b rdata %h required 1 1 0", m_ready, m_error, m_rdata);
    end
    tick();
    s_rdata = '0;
  endtask

  task automatic test_timeout();
    m_ren = 1'b1; m_addr = 32'h1004;
    tick();
    m_ren = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (s_sel !== 4'b0010 || m_ready !== 1'b0) begin
        n_fail++; $display("FAIL to_access_c%0d: sel %b ready %b required 0010 0", c, s_sel, m_ready);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_error !== 1'b1 || m_rdata !== 32'h0 || s_sel !== 4'b0000) begin
      n_fail++; $display("FAIL to_resp: ready %b err %b rdata %h sel %b required 1 1 0 0000", m_ready, m_error, m_rdata, s_sel);
    end
    tick();
    m_ren = 1'b1; m_addr = 32'h0020;
    tick();
    m_ren = 1'b0;
    s_ready = 4'b0001; s_rdata[0 +: DW] = 32'hA5A50001;
    @(negedge clk);
    n_checks++;
    if (s_sel !== 4'b0001) begin
      n_fail++; $display("FAIL to_next_sel: got %b required 0001", s_sel);
    end
    tick();
    s_ready = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_error !== 1'b0 || m_rdata !== 32'hA5A50001) begin
      n_fail++; $display("FAIL to_next_resp: ready %b err %b rdata %h required 1 0 a5a50001", m_ready, m_error, m_rdata);
    end
    tick();
    s_rdata = '0;
  endtask

  task automatic test_ready_wins();
    m_ren = 1'b1; m_addr = 32'h1004;
    tick();
    m_ren = 1'b0;
    tick(); tick(); tick();
    s_ready = 4'b0010; s_rdata[1*DW +: DW] = 32'h0BADF00D;
    @(negedge clk);
    n_checks++;
    if (s_sel !== 4'b0010) begin
      n_fail++; $display("FAIL rw_last_sel: got %b required 0010", s_sel);
    end
    tick();
    s_ready = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_error !== 1'b0 || m_rdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL ready_wins: ready %b err %b rdata %h required 1 0 0badf00d", m_ready, m_error, m_rdata);
    end
    tick();
    s_rdata = '0;
  endtask

  task automatic test_overlap();
    logic [AW-1:0] addrs [6];
    logic [SC-1:0] sels  [6];
    addrs = '{32'h90, 32'h100, 32'h7F, 32'h1FF, 32'h200, 32'h1000};
    sels  = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    set_win(0, 32'h300, 32'h100);
    set_win(1, 32'h0, 32'h100);
    set_win(2, 32'h80, 32'h200);
    set_win(3, 32'h1000, 32'h1000);
    for (int k = 0; k < 6; k++) begin
      m_ren = 1'b1; m_addr = addrs[k];
      tick();
      m_ren = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sels[k] == 4'b0000) begin
        if (m_ready !== 1'b1 || m_error !== 1'b1 || s_sel !== 4'b0000) begin
          n_fail++; $display("FAIL ovl_unmapped_%h: ready %b err %b sel %b required 1 1 0000", addrs[k], m_ready, m_error, s_sel);
        end
      end else begin
        if (s_sel !== sels[k]) begin
          n_fail++; $display("FAIL ovl_sel_%h: got %b required %b", addrs[k], s_sel, sels[k]);
        end
        s_ready = sels[k];
        tick();
        s_ready = '0;
        @(negedge clk);
        n_checks++;
        if (m_ready !== 1'b1 || m_error !== 1'b0) begin
          n_fail++; $display("FAIL ovl_resp_%h: ready %b err %b required 1 0", addrs[k], m_ready, m_error);
        end
      end
      tick();
    end
    std_map();
  endtask

  task automatic test_reset_mid();
    m_ren = 1'b1; m_addr = 32'h1004;
    tick();
    m_ren = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_sel !== 4'b0010) begin
      n_fail++; $display("FAIL rstmid_pre_sel: got %b required 0010", s_sel);
    end
    tick();
    s_ready = 4'b0010;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (s_sel !== 4'b0000 || m_ready !== 1'b0 || s_ren !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_drop: sel %b ready %b ren %b required 0000 0 0", s_sel, m_ready, s_ren);
    end
    @(negedge clk);
    tick();
    @(negedge clk);
    rst = 1'b0;
    s_ready = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (m_ready !== 1'b0 || s_sel !== 4'b0000) begin
        n_fail++; $display("FAIL rstmid_quiet_%0d: ready %b sel %b required 0 0000", c, m_ready, s_sel);
      end
    end
    tick();
    m_wen = 1'b1; m_addr = 32'h0000; m_wdata = 32'h99;
    tick();
    m_wen = 1'b0;
    s_ready = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (s_sel !== 4'b0001 || s_wen !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_new_access: sel %b wen %b required 0001 1", s_sel, s_wen);
    end
    tick();
    s_ready = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_error !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_new_resp: ready %b err %b required 1 0", m_ready, m_error);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    m_ren = 1'b1; m_addr = 32'h0010;
    tick();
    m_ren = 1'b0;
    s_ready = 4'b0001; s_rdata[0 +: DW] = 32'h11111111;
    tick();
    s_ready = '0;
    m_ren = 1'b1; m_addr = 32'h1008;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_rdata !== 32'h11111111) begin
      n_fail++; $display("FAIL b2b_first: ready %b rdata %h required 1 11111111", m_ready, m_rdata);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0 || s_sel !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_idle: ready %b sel %b required 0 0000", m_ready, s_sel);
    end
    tick();
    m_ren = 1'b0; m_addr = '0;
    s_ready = 4'b0010; s_rdata[1*DW +: DW] = 32'h22222222;
    @(negedge clk);
    n_checks++;
    if (s_sel !== 4'b0010 || s_addr !== 32'h1008) begin
      n_fail++; $display("FAIL b2b_second_access: sel %b addr %h required 0010 1008", s_sel, s_addr);
    end
    tick();
    s_ready = '0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_rdata !== 32'h22222222 || m_error !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_resp: ready %b rdata %h err %b required 1 22222222 0", m_ready, m_rdata, m_error);
    end
    tick();
    s_rdata = '0;
  endtask

  initial begin
    test_reset();
    test_read_mapped();
    test_write();
    test_rw_both();
    test_unmapped();
    test_slave_error();
    test_timeout();
    test_ready_wins();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
